// File: rtl/rtc_calendar.sv
// rtc_calendar: BCD real-time clock/calendar (seconds through year 0000-9999)
// with Gregorian leap years, validated parallel load and 12/24 h display.
// Optional alarm compare logic is included when RTC_ALARM_EN is defined.
module rtc_calendar #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter logic [15:0] RST_YEAR      = 16'h2024,
   parameter logic [7:0]  RST_MONTH     = 8'h01,
   parameter logic [7:0]  RST_DAY       = 8'h01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mode,
   input  logic        ld_valid,
   input  logic [7:0]  ld_sec,
   input  logic [7:0]  ld_min,
   input  logic [7:0]  ld_hour,
   input  logic [7:0]  ld_day,
   input  logic [7:0]  ld_month,
   input  logic [15:0] ld_year,
`ifdef RTC_ALARM_EN
   input  logic        al_set,
   input  logic [7:0]  al_hour,
   input  logic [7:0]  al_min,
   output logic        alarm,
`endif
   output logic        ld_err,
   output logic        sec_tick,
   output logic [7:0]  sec_bcd,
   output logic [7:0]  min_bcd,
   output logic [7:0]  hour_bcd,
   output logic [7:0]  day_bcd,
   output logic [7:0]  month_bcd,
   output logic [15:0] year_bcd,
   output logic        pm
);

   localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICKS_PER_SEC - 1);

   // A BCD pair is divisible by 4 when: tens even and units in {0,4,8},
   // or tens odd and units in {2,6}.
   function automatic logic pair_div4(input logic [7:0] p);
      logic r;
      if (p[4]) r = (p[3:0] == 4'd2) || (p[3:0] == 4'd6);
      else      r = (p[3:0] == 4'd0) || (p[3:0] == 4'd4) || (p[3:0] == 4'd8);
      return r;
   endfunction

   // Century years (low pair 00) are leap only when the high pair is /4.
   function automatic logic is_leap(input logic [15:0] y);
      return (y[7:0] == 8'h00) ? pair_div4(y[15:8]) : pair_div4(y[7:0]);
   endfunction

   function automatic logic [7:0] month_len(input logic [7:0] m, input logic [15:0] y);
      logic [7:0] r;
      case (m)
         8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
         8'h02:                      r = is_leap(y) ? 8'h29 : 8'h28;
         default:                    r = 8'h31;
      endcase
      return r;
   endfunction

   function automatic logic bcd_ok8(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
      return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Ripple a +1 through four BCD digits; 9999 naturally wraps to 0000.
   function automatic logic [15:0] bcd_inc16(input logic [15:0] y);
      logic [15:0] r;
      logic        carry;
      r     = y;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Returns {pm, hour} for 12 h display of a 24 h BCD hour.
   function automatic logic [8:0] hour_12h(input logic [7:0] h);
      logic [8:0] r;
      if (h == 8'h00)      r = {1'b0, 8'h12};
      else if (h < 8'h12)  r = {1'b0, h};
      else if (h == 8'h12) r = {1'b1, 8'h12};
      else if (h < 8'h20)  r = {1'b1, h - 8'h12};
      else if (h < 8'h22)  r = {1'b1, 4'h0, h[3:0] + 4'h8};
      else                 r = {1'b1, 4'h1, h[3:0] - 4'h2};
      return r;
   endfunction

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
   logic [7:0]       day_q, day_d, month_q, month_d;
   logic [15:0]      year_q, year_d;
   logic [7:0]       hour_disp_q, hour_disp_d;
   logic             pm_q, pm_d;
   logic             tick_q, tick_d;
   logic             ld_err_q, ld_err_d;
   logic             terminal, ld_ok;

   assign terminal = (cnt_q == CNT_TERM);

   assign ld_ok = bcd_ok8(ld_sec) && bcd_ok8(ld_min) && bcd_ok8(ld_hour) &&
                  bcd_ok8(ld_day) && bcd_ok8(ld_month) &&
                  bcd_ok8(ld_year[15:8]) && bcd_ok8(ld_year[7:0]) &&
                  (ld_sec <= 8'h59) && (ld_min <= 8'h59) && (ld_hour <= 8'h23) &&
                  (ld_month >= 8'h01) && (ld_month <= 8'h12) &&
                  (ld_day >= 8'h01) && (ld_day <= month_len(ld_month, ld_year));

   // Next state: a valid load beats the tick; otherwise prescale and cascade.
   always_comb begin
      cnt_d    = cnt_q;
      sec_d    = sec_q;
      min_d    = min_q;
      hour_d   = hour_q;
      day_d    = day_q;
      month_d  = month_q;
      year_d   = year_q;
      tick_d   = 1'b0;
      ld_err_d = 1'b0;
      if (ld_valid && ld_ok) begin
         cnt_d   = '0;
         sec_d   = ld_sec;
         min_d   = ld_min;
         hour_d  = ld_hour;
         day_d   = ld_day;
         month_d = ld_month;
         year_d  = ld_year;
      end else begin
         ld_err_d = ld_valid;
         if (terminal) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (sec_q == 8'h59) begin
               sec_d = 8'h00;
               if (min_q == 8'h59) begin
                  min_d = 8'h00;
                  if (hour_q == 8'h23) begin
                     hour_d = 8'h00;
                     if (day_q == month_len(month_q, year_q)) begin
                        day_d = 8'h01;
                        if (month_q == 8'h12) begin
                           month_d = 8'h01;
                           year_d  = bcd_inc16(year_q);
                        end else begin
                           month_d = bcd_inc8(month_q);
                        end
                     end else begin
                        day_d = bcd_inc8(day_q);
                     end
                  end else begin
                     hour_d = bcd_inc8(hour_q);
                  end
               end else begin
                  min_d = bcd_inc8(min_q);
               end
            end else begin
               sec_d = bcd_inc8(sec_q);
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (mode) {pm_d, hour_disp_d} = hour_12h(hour_d);
      else      {pm_d, hour_disp_d} = {1'b0, hour_d};
   end

   // Time/date registers, display registers and pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         sec_q       <= 8'h00;
         min_q       <= 8'h00;
         hour_q      <= 8'h00;
         day_q       <= RST_DAY;
         month_q     <= RST_MONTH;
         year_q      <= RST_YEAR;
         hour_disp_q <= 8'h00;
         pm_q        <= 1'b0;
         tick_q      <= 1'b0;
         ld_err_q    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hour_q      <= hour_d;
         day_q       <= day_d;
         month_q     <= month_d;
         year_q      <= year_d;
         hour_disp_q <= hour_disp_d;
         pm_q        <= pm_d;
         tick_q      <= tick_d;
         ld_err_q    <= ld_err_d;
      end
   end

   assign sec_tick  = tick_q;
   assign ld_err    = ld_err_q;
   assign sec_bcd   = sec_q;
   assign min_bcd   = min_q;
   assign hour_bcd  = hour_disp_q;
   assign day_bcd   = day_q;
   assign month_bcd = month_q;
   assign year_bcd  = year_q;
   assign pm        = pm_q;

`ifdef RTC_ALARM_EN
   logic [7:0] al_hour_q, al_hour_d, al_min_q, al_min_d;
   logic       al_armed_q, al_armed_d, alarm_q, alarm_d;

   // Alarm fires only on a real tick into HH:MM:00, never on a load.
   always_comb begin
      al_hour_d  = al_hour_q;
      al_min_d   = al_min_q;
      al_armed_d = al_armed_q;
      if (al_set) begin
         al_hour_d  = al_hour;
         al_min_d   = al_min;
         al_armed_d = 1'b1;
      end
      alarm_d = tick_d && al_armed_q && (hour_d == al_hour_q) &&
                (min_d == al_min_q) && (sec_d == 8'h00);
   end

   // Alarm setting and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         al_hour_q  <= 8'h00;
         al_min_q   <= 8'h00;
         al_armed_q <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         al_hour_q  <= al_hour_d;
         al_min_q   <= al_min_d;
         al_armed_q <= al_armed_d;
         alarm_q    <= alarm_d;
      end
   end

   assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_rtc_calendar.sv
// tb_rtc_calendar: randomized + directed scoreboard bench for rtc_calendar
// (default build, TICKS_PER_SEC = 4). Expected events come from an integer
// calendar model; a monitor pops them when sec_tick / ld_err appear.
module tb_rtc_calendar;

   localparam int TPS = 4;

   logic        clk = 1'b0;
   logic        rst, mode, ld_valid;
   logic [7:0]  ld_sec, ld_min, ld_hour, ld_day, ld_month;
   logic [15:0] ld_year;
   logic        ld_err, sec_tick, pm;
   logic [7:0]  sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd;
   logic [15:0] year_bcd;

   rtc_calendar #(
      .TICKS_PER_SEC(TPS),
      .RST_YEAR(16'h2024),
      .RST_MONTH(8'h01),
      .RST_DAY(8'h01)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .ld_valid(ld_valid),
      .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
      .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year),
      .ld_err(ld_err), .sec_tick(sec_tick),
      .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd),
      .day_bcd(day_bcd), .month_bcd(month_bcd), .year_bcd(year_bcd),
      .pm(pm)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_err;
      logic [7:0]  sec, min, hour_disp, day, month;
      logic [15:0] year;
      logic        pm;
   } exp_t;

   exp_t exp_q[$];
   int   vec_cnt = 0;
   int   mis_cnt = 0;
   int   m_cnt, m_sec, m_min, m_hour, m_day, m_mon, m_year;
   bit   cur_mode = 1'b0;

   function automatic bit leap(input int y);
      return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
   endfunction

   function automatic int days_in(input int mo, input int y);
      int d;
      case (mo)
         4, 6, 9, 11: d = 30;
         2:           d = leap(y) ? 29 : 28;
         default:     d = 31;
      endcase
      return d;
   endfunction

   function automatic logic [7:0] to_bcd2(input int v);
      return 8'(((v / 10) << 4) + (v % 10));
   endfunction

   function automatic logic [15:0] to_bcd4(input int v);
      return {to_bcd2(v / 100), to_bcd2(v % 100)};
   endfunction

   function automatic bit digits_ok(input logic [15:0] b);
      return (b[15:12] < 10) && (b[11:8] < 10) && (b[7:4] < 10) && (b[3:0] < 10);
   endfunction

   function automatic int bcd_val(input logic [15:0] b);
      return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
   endfunction

   function automatic exp_t mk(input bit is_err, input bit md);
      exp_t e;
      int   dh;
      e.is_err = is_err;
      e.sec    = to_bcd2(m_sec);
      e.min    = to_bcd2(m_min);
      e.day    = to_bcd2(m_day);
      e.month  = to_bcd2(m_mon);
      e.year   = to_bcd4(m_year);
      if (md) begin
         dh   = (m_hour == 0) ? 12 : ((m_hour > 12) ? m_hour - 12 : m_hour);
         e.pm = (m_hour >= 12);
      end else begin
         dh   = m_hour;
         e.pm = 1'b0;
      end
      e.hour_disp = to_bcd2(dh);
      return e;
   endfunction

   task automatic advance();
      m_sec++;
      if (m_sec == 60) begin m_sec = 0; m_min++; end
      if (m_min == 60) begin m_min = 0; m_hour++; end
      if (m_hour == 24) begin m_hour = 0; m_day++; end
      if (m_day > days_in(m_mon, m_year)) begin m_day = 1; m_mon++; end
      if (m_mon == 13) begin m_mon = 1; m_year++; end
      if (m_year == 10000) m_year = 0;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         mis_cnt++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus; the model predicts the edge that follows.
   task automatic step(input bit ld, input logic [7:0] s, input logic [7:0] mi,
                       input logic [7:0] h, input logic [7:0] d, input logic [7:0] mo,
                       input logic [15:0] y);
      bit ok;
      int vs, vmi, vh, vd, vmo, vy;
      @(negedge clk);
      rst      = 1'b0;
      mode     = cur_mode;
      ld_valid = ld;
      ld_sec   = s;  ld_min = mi; ld_hour = h;
      ld_day   = d;  ld_month = mo; ld_year = y;
      vs = bcd_val({8'h00, s});  vmi = bcd_val({8'h00, mi}); vh = bcd_val({8'h00, h});
      vd = bcd_val({8'h00, d});  vmo = bcd_val({8'h00, mo}); vy = bcd_val(y);
      ok = digits_ok({s, mi}) && digits_ok({h, d}) && digits_ok({mo, 8'h00}) && digits_ok(y) &&
           vs <= 59 && vmi <= 59 && vh <= 23 && vmo >= 1 && vmo <= 12 &&
           vd >= 1 && vd <= days_in(vmo, vy);
      if (ld && ok) begin
         m_sec = vs; m_min = vmi; m_hour = vh; m_day = vd; m_mon = vmo; m_year = vy;
         m_cnt = 0;
      end else begin
         if (m_cnt == TPS - 1) begin
            m_cnt = 0;
            advance();
            exp_q.push_back(mk(1'b0, cur_mode));
         end else begin
            m_cnt++;
         end
         if (ld) exp_q.push_back(mk(1'b1, cur_mode));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
   endtask

   // Load, then run long enough for the following tick to be observed.
   task automatic load_run(input logic [7:0] s, input logic [7:0] mi, input logic [7:0] h,
                           input logic [7:0] d, input logic [7:0] mo, input logic [15:0] y);
      step(1'b1, s, mi, h, d, mo, y);
      idle(TPS + 1);
   endtask

   task automatic load_at_terminal(input logic [7:0] s, input logic [7:0] mi, input logic [7:0] h,
                                   input logic [7:0] d, input logic [7:0] mo, input logic [15:0] y);
      while (m_cnt != TPS - 1) idle(1);
      load_run(s, mi, h, d, mo, y);
   endtask

   // Monitor: every sec_tick / ld_err must match the oldest expected event.
   task automatic check_event(input bit is_err);
      exp_t e;
      if (exp_q.size() == 0) begin
         vec_cnt++;
         mis_cnt++;
         $display("FAIL unexpected_event: got %s pulse, expected none",
                  is_err ? "ld_err" : "sec_tick");
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", 16'(is_err), 16'(e.is_err));
         chk("sec", 16'(sec_bcd), 16'(e.sec));
         chk("min", 16'(min_bcd), 16'(e.min));
         chk("hour", 16'(hour_bcd), 16'(e.hour_disp));
         chk("pm", 16'(pm), 16'(e.pm));
         chk("day", 16'(day_bcd), 16'(e.day));
         chk("month", 16'(month_bcd), 16'(e.month));
         chk("year", year_bcd, e.year);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (sec_tick === 1'b1) check_event(1'b0);
            if (ld_err === 1'b1) check_event(1'b1);
         end
      end
   end

   initial begin
      int y, mo, d, h, mi, s, fld;
      logic [7:0]  b_s, b_mi, b_h, b_d, b_mo;
      logic [15:0] b_y;
      // Reset with a valid load pending: reset must win.
      rst = 1'b1; mode = 1'b0; ld_valid = 1'b1;
      ld_sec = 8'h56; ld_min = 8'h34; ld_hour = 8'h12;
      ld_day = 8'h15; ld_month = 8'h06; ld_year = 16'h1999;
      repeat (3) @(negedge clk);
      chk("rst_sec", 16'(sec_bcd), 16'h00);
      chk("rst_min", 16'(min_bcd), 16'h00);
      chk("rst_hour", 16'(hour_bcd), 16'h00);
      chk("rst_day", 16'(day_bcd), 16'h01);
      chk("rst_month", 16'(month_bcd), 16'h01);
      chk("rst_year", year_bcd, 16'h2024);
      chk("rst_tick", 16'(sec_tick), 16'h0);
      chk("rst_ld_err", 16'(ld_err), 16'h0);
      chk("rst_pm", 16'(pm), 16'h0);
      m_cnt = 0; m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 2024;

      idle(2 * TPS + 1);
      // Full rollover of every field.
      load_run(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 16'h9999);
      // Leap rule around February.
      load_run(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 16'h2024);
      load_run(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 16'h2100);
      load_run(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 16'h2000);
      load_run(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 16'h2023);
      load_run(8'h59, 8'h59, 8'h23, 8'h29, 8'h02, 16'h2024);
      // Rejected loads.
      load_run(8'h5A, 8'h00, 8'h10, 8'h01, 8'h01, 16'h2024);
      load_run(8'h00, 8'h00, 8'h10, 8'h31, 8'h04, 16'h2024);
      load_run(8'h00, 8'h00, 8'h10, 8'h29, 8'h02, 16'h2100);
      load_run(8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 16'h2024);
      // 12 h display of 00, 12 and 13 o'clock.
      cur_mode = 1'b1;
      load_run(8'h59, 8'h59, 8'h23, 8'h10, 8'h05, 16'h2024);
      load_run(8'h59, 8'h59, 8'h11, 8'h10, 8'h05, 16'h2024);
      load_run(8'h59, 8'h59, 8'h12, 8'h10, 8'h05, 16'h2024);
      cur_mode = 1'b0;
      // Loads coincident with terminal count: valid drops tick, invalid keeps it.
      load_at_terminal(8'h30, 8'h20, 8'h10, 8'h15, 8'h07, 16'h2030);
      load_at_terminal(8'h60, 8'h20, 8'h10, 8'h15, 8'h07, 16'h2030);

      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 9) == 0) cur_mode = 1'($urandom_range(0, 1));
         idle(int'($urandom_range(0, 5)));
         case ($urandom_range(0, 5))
            0: y = 2000;
            1: y = 2100;
            2: y = 9999;
            default: y = int'($urandom_range(0, 9999));
         endcase
         mo = int'($urandom_range(1, 12));
         d  = $urandom_range(0, 1) ? days_in(mo, y) : int'($urandom_range(1, days_in(mo, y)));
         h  = $urandom_range(0, 1) ? 23 : int'($urandom_range(0, 23));
         mi = $urandom_range(0, 1) ? 59 : int'($urandom_range(0, 59));
         s  = $urandom_range(0, 3) != 0 ? 59 : int'($urandom_range(0, 59));
         b_s = to_bcd2(s); b_mi = to_bcd2(mi); b_h = to_bcd2(h);
         b_d = to_bcd2(d); b_mo = to_bcd2(mo); b_y = to_bcd4(y);
         if ($urandom_range(0, 3) == 0) begin
            fld = int'($urandom_range(0, 5));
            case (fld)
               0: b_s  = 8'($urandom_range(0, 255));
               1: b_mi = 8'($urandom_range(0, 255));
               2: b_h  = 8'($urandom_range(0, 255));
               3: b_d  = to_bcd2(days_in(mo, y) + 1);
               4: b_mo = $urandom_range(0, 1) ? 8'h00 : 8'h13;
               default: b_y = 16'($urandom_range(0, 65535));
            endcase
         end
         step(1'b1, b_s, b_mi, b_h, b_d, b_mo, b_y);
      end

      idle(2 * TPS + 2);
      chk("pending_events", 16'(exp_q.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

endmodule

// File: doc/rtc_calendar.md
# rtc_calendar

Parametrised real-time clock/calendar: divides the system clock to a 1 Hz tick and keeps seconds through years (0000–9999) entirely in BCD, with the full Gregorian leap-year rule. Adds a validated parallel time/date load, 12/24-hour display mode and a programmable reset date. Sits between the system clock domain and the 7-segment decoders; every digit output feeds a BCD-to-segment decoder directly.

## Interface
- TICKS_PER_SEC, 50_000_000: clk cycles per second; ≥1 (1 = one second per cycle).
- RST_YEAR, 16'h2024: reset year, 4 BCD digits.
- RST_MONTH, 8'h01: reset month, BCD.
- RST_DAY, 8'h01: reset day, BCD; must be legal for RST_MONTH/RST_YEAR.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- mode  in  1  0 = 24 h hour display, 1 = 12 h display.
- ld_valid  in  1  single-cycle load strobe.
- ld_sec, ld_min, ld_hour, ld_day, ld_month  in  8 each  BCD load values (hour always 24 h form).
- ld_year  in  16  BCD load year.
- ld_err  out  1  one-cycle pulse: last load rejected.
- sec_tick  out  1  one-cycle pulse on each second advance.
- sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd  out  8 each  BCD digits.
- year_bcd  out  16  BCD year.
- pm  out  1  12 h mode: 1 when internal hour ≥ 12; 0 in 24 h mode.

## Operation
- Internal state: prescaler cnt (clog2(TICKS_PER_SEC) bits) plus BCD registers sec, min, hour (00–23), day, month, year.
- Prescaler counts 0..TICKS_PER_SEC-1; at terminal count wraps to 0 and asserts sec_tick for that cycle; the tick advances time on the same edge.
- Cascade on tick: sec 59→00 carries to min; min 59→00 carries to hour; hour 23→00 carries to day; day at month length → 01 carries to month; month 12→01 carries to year; year 9999→0000.
- Month length: 31 for 01,03,05,07,08,10,12; 30 for 04,06,09,11; Feb 29 if leap else 28.
- Leap: year%4==0 and (year%100!=0 or year%400==0). Computed on BCD: a 2-digit pair is divisible by 4 iff (tens even, units ∈{0,4,8}) or (tens odd, units ∈{2,6}); low pair 00 → test high pair instead.
- Digit increments are BCD (x9 → (x+1)0); no binary adder on the full field.
- Load: on ld_valid, all six fields checked — every nibble ≤9, sec/min ≤59, hour ≤23, month 01–12, day 01..length(ld_month, ld_year). Valid: all registers take load values, prescaler cleared to 0, no tick that cycle. Invalid: state unchanged, prescaler keeps counting, ld_err pulses next cycle.
- Load and terminal count in same cycle: load wins (valid or invalid load, tick is dropped/kept respectively: invalid load lets tick proceed).
- Display: 24 h passes hour through. 12 h maps 00→12 pm=0, 01–11 as is pm=0, 12→12 pm=1, 13–23→01–11 pm=1.

## Timing
- All outputs registered; counter outputs change on the edge where sec_tick is high or a valid load is accepted.
- mode change reflected on hour_bcd/pm one cycle after mode is sampled.
- ld_err asserted exactly one cycle after the rejected ld_valid, for one cycle.
- Reset: sec/min/hour 00, day RST_DAY, month RST_MONTH, year RST_YEAR, cnt 0, sec_tick 0, ld_err 0; hour_bcd 00 (12 if mode=1 on first post-reset cycle), pm 0. Reset overrides load and tick; first tick TICKS_PER_SEC cycles after rst deasserts.

## Configuration
- RTC_ALARM_EN defined: adds inputs al_set (1), al_hour (8), al_min (8) and output alarm (1). al_set latches al_hour/al_min (reset 00:00, alarm disarmed until first al_set); alarm pulses one cycle, coincident with sec_tick, when the new time is al_hour:al_min:00. A load landing on the alarm time does not fire it.
- Undefined: alarm ports and logic absent; all other behaviour identical.

## Test plan
- TICKS_PER_SEC=4, reset: outputs 00:00:00 01/01/2024; first sec_tick on 4th cycle after reset release; sec_bcd=01.
- Load 23:59:59 31/12/9999, one tick -> 00:00:00 01/01/0000.
- Leap: load 23:59:59 28/02 for years 2024, 2100, 2000, 2023 -> next day 29/02, 01/03, 29/02, 01/03.
- Invalid loads (sec 8'h5A, day 31/04, day 29/02/2100, month 00) -> ld_err one-cycle pulse, state and tick cadence unchanged.
- mode=1 with hours 00, 12, 13 -> hour_bcd 12/pm0, 12/pm1, 01/pm1; valid load coincident with terminal count -> loaded value held, no sec_tick.
- RTC_ALARM_EN: al_set 07:30, load 07:29:59, tick -> alarm pulse with sec_tick; load 07:30:00 directly -> no pulse.
